// File: rtl/spi_nor_reader_if.sv
// rtl/spi_nor_reader_if.sv - request/response bus of the SPI NOR reader
interface spi_nor_reader_if;
  logic        req;
  logic        ready;
  logic [23:0] addr;
  logic [1:0]  size;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, size, input ready, rvalid, rdata);
  modport slave  (input req, addr, size, output ready, rvalid, rdata);
endinterface

// File: rtl/spi_nor_reader.sv
// rtl/spi_nor_reader.sv - 1-1-1 SPI NOR read controller, mode 0, 1/2/4 byte reads
module spi_nor_reader #(
  parameter int unsigned CLK_DIV  = 2,
  parameter logic [7:0]  READ_CMD = 8'h03
) (
  input  logic            clk,
  input  logic            rst,
  spi_nor_reader_if.slave bus,
  output logic            nor_sck,
  output logic            nor_csb,
  output logic            nor_mosi,
  input  logic            nor_miso
);
  typedef enum logic [1:0] {IDLE, SHIFT_OUT, SHIFT_IN, DESELECT} state_t;

  localparam logic [8:0] HALF_LAST  = 9'(CLK_DIV - 1);
  localparam logic [8:0] DESEL_LAST = 9'(2 * CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [5:0]  bit_q, bit_d;
  logic [5:0]  last_q, last_d;
  logic [31:0] shreg_q, shreg_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] rdata_q, rdata_d;
  logic        sck_q, sck_d;
  logic        csb_q, csb_d;
  logic        mosi_q, mosi_d;
  logic        ready_q, ready_d;
  logic        rvalid_q, rvalid_d;
  logic        tail_q, tail_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    last_d   = last_q;
    shreg_d  = shreg_q;
    rx_d     = rx_q;
    rdata_d  = rdata_q;
    sck_d    = sck_q;
    csb_d    = csb_q;
    mosi_d   = mosi_q;
    ready_d  = ready_q;
    rvalid_d = 1'b0;
    tail_d   = tail_q;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (bus.req && ready_q) begin
          state_d = SHIFT_OUT;
          ready_d = 1'b0;
          csb_d   = 1'b0;
          sck_d   = 1'b0;
          shreg_d = {READ_CMD, bus.addr};
          mosi_d  = READ_CMD[7];
          cnt_d   = '0;
          bit_d   = '0;
          rx_d    = '0;
          tail_d  = 1'b0;
          case (bus.size)
            2'd0:    last_d = 6'd39;
            2'd1:    last_d = 6'd47;
            default: last_d = 6'd63;
          endcase
        end
      end

      SHIFT_OUT, SHIFT_IN: begin
        if (tail_q) begin
          // sck is already low; hold csb for one more half period before releasing
          if (cnt_q == HALF_LAST) begin
            state_d  = DESELECT;
            csb_d    = 1'b1;
            rvalid_d = 1'b1;
            rdata_d  = rx_q;
            cnt_d    = '0;
            tail_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end else if (cnt_q != HALF_LAST) begin
          cnt_d = cnt_q + 9'd1;
        end else begin
          cnt_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
            // data bit k lands in byte (k-32)/8, MSB first within the byte
            if (state_q == SHIFT_IN) rx_d[{bit_q[4:3], ~bit_q[2:0]}] = nor_miso;
          end else begin
            sck_d = 1'b0;
            if (bit_q == last_q) begin
              tail_d = 1'b1;
            end else begin
              bit_d   = bit_q + 6'd1;
              shreg_d = {shreg_q[30:0], 1'b0};
              mosi_d  = (state_q == SHIFT_OUT && bit_q != 6'd31) ? shreg_q[30] : 1'b0;
              if (bit_q == 6'd31) state_d = SHIFT_IN;
            end
          end
        end
      end

      DESELECT: begin
        if (cnt_q == DESEL_LAST) begin
          state_d = IDLE;
          ready_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      last_q   <= '0;
      shreg_q  <= '0;
      rx_q     <= '0;
      rdata_q  <= '0;
      sck_q    <= 1'b0;
      csb_q    <= 1'b1;
      mosi_q   <= 1'b0;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      tail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      last_q   <= last_d;
      shreg_q  <= shreg_d;
      rx_q     <= rx_d;
      rdata_q  <= rdata_d;
      sck_q    <= sck_d;
      csb_q    <= csb_d;
      mosi_q   <= mosi_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      tail_q   <= tail_d;
    end
  end

  assign nor_sck    = sck_q;
  assign nor_csb    = csb_q;
  assign nor_mosi   = mosi_q;
  assign bus.ready  = ready_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
endmodule

// File: tb/tb_spi_nor_reader.sv
// tb/tb_spi_nor_reader.sv - directed bench for spi_nor_reader at CLK_DIV 1 and 2
module tb_spi_nor_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_a  [2];
  logic [23:0] addr_a [2];
  logic [1:0]  size_a [2];
  wire         rdy_w  [2];
  wire         rv_w   [2];
  wire  [31:0] rd_w   [2];
  wire         sck_w  [2];
  wire         csb_w  [2];
  wire         mosi_w [2];
  wire  [31:0] cap_w  [2];
  wire  [31:0] nbits_w[2];

  logic [7:0] mem [0:511];
  int n_vec = 0;
  int n_err = 0;
  int hi_run = 0;
  int last_gap = 0;

  // instance 0 runs with CLK_DIV=1, instance 1 with CLK_DIV=2; each has its own flash model
  for (genvar g = 0; g < 2; g++) begin : u
    spi_nor_reader_if bus ();
    logic        miso = 1'b0;
    logic [31:0] sh   = '0;
    int          cnt  = 0;
    logic [8:0]  ma;
    logic [7:0]  mb;

    assign bus.req     = req_a[g];
    assign bus.addr    = addr_a[g];
    assign bus.size    = size_a[g];
    assign rdy_w[g]    = bus.ready;
    assign rv_w[g]     = bus.rvalid;
    assign rd_w[g]     = bus.rdata;
    assign cap_w[g]    = sh;
    assign nbits_w[g]  = cnt;

    spi_nor_reader #(.CLK_DIV(g + 1), .READ_CMD(8'h03)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .nor_sck  (sck_w[g]),
      .nor_csb  (csb_w[g]),
      .nor_mosi (mosi_w[g]),
      .nor_miso (miso)
    );

    always @(posedge sck_w[g] or negedge csb_w[g]) begin
      if (sck_w[g]) begin
        if (cnt < 32) sh = {sh[30:0], mosi_w[g]};
        cnt = cnt + 1;
      end else begin
        cnt = 0;
      end
    end

    always @(negedge sck_w[g]) begin
      if (!csb_w[g] && cnt >= 32) begin
        ma   = sh[8:0] + 9'((cnt - 32) / 8);
        mb   = mem[ma];
        miso = mb[3'(7 - ((cnt - 32) % 8))];
      end
    end
  end

  always @(negedge clk) begin
    if (csb_w[1]) hi_run++;
    else begin
      if (hi_run > 0) last_gap = hi_run;
      hi_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input int g, input logic [23:0] a, input logic [1:0] sz,
                         output int rv_c, output int rdy_c, output logic [31:0] data,
                         output int n_rv, output logic csb1);
    int k = 0;
    int c = 0;
    while (!rdy_w[g] && k < 1000) begin
      @(negedge clk);
      k++;
    end
    req_a[g] = 1'b1; addr_a[g] = a; size_a[g] = sz;
    rv_c = -1; rdy_c = -1; data = '0; n_rv = 0; csb1 = 1'b1;
    while (rdy_c < 0 && c < 2000) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        req_a[g] = 1'b0;
        csb1 = csb_w[g];
      end
      if (rv_w[g]) begin
        n_rv++;
        rv_c = c;
        data = rd_w[g];
      end
      if (rdy_w[g]) rdy_c = c;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rv_c, rdy_c, n_rv, n_acc, n_bv;
    logic [31:0] data;
    logic csb1;
    logic [23:0] acc_q[$];
    logic [23:0] a;

    for (int i = 0; i < 512; i++) mem[i] = 8'(i * 7 + 3);
    mem[9'h010] = 8'hA5;
    mem[9'h100] = 8'h11; mem[9'h101] = 8'h22; mem[9'h102] = 8'h33; mem[9'h103] = 8'h44;
    for (int i = 0; i < 8; i++) mem[i] = 8'hC0 + 8'(i);
    for (int g = 0; g < 2; g++) begin
      req_a[g] = 1'b0; addr_a[g] = '0; size_a[g] = '0;
    end

    // reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("rst_csb%0d", g), 32'(csb_w[g]), 32'd1);
      check($sformatf("rst_sck%0d", g), 32'(sck_w[g]), 32'd0);
      check($sformatf("rst_mosi%0d", g), 32'(mosi_w[g]), 32'd0);
      check($sformatf("rst_rvalid%0d", g), 32'(rv_w[g]), 32'd0);
      check($sformatf("rst_rdata%0d", g), rd_w[g], 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) check($sformatf("rst_ready%0d", g), 32'(rdy_w[g]), 32'd1);

    // single byte, CLK_DIV=1
    do_read(0, 24'h000010, 2'd0, rv_c, rdy_c, data, n_rv, csb1);
    check("b1_csb_c1", 32'(csb1), 32'd0);
    check("b1_mosi", cap_w[0], 32'h03000010);
    check("b1_rv_cyc", rv_c, 32'd82);
    check("b1_rdata", data, 32'h000000A5);
    check("b1_rdy_cyc", rdy_c, 32'd84);
    check("b1_nrv", n_rv, 32'd1);
    check("b1_sck_edges", nbits_w[0], 32'd40);

    // word, CLK_DIV=2
    do_read(1, 24'h000100, 2'd2, rv_c, rdy_c, data, n_rv, csb1);
    check("w_mosi", cap_w[1], 32'h03000100);
    check("w_rv_cyc", rv_c, 32'd259);
    check("w_rdata", data, 32'h44332211);
    check("w_rdy_cyc", rdy_c, 32'd263);
    check("w_nrv", n_rv, 32'd1);
    check("w_sck_edges", nbits_w[1], 32'd64);

    // busy rejection: req held high, addr changing every cycle
    n_acc = 0; n_bv = 0;
    for (int c = 0; c < 400; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (rv_w[0]) begin
          n_bv++;
          check("busy_rv_expected", 32'(acc_q.size() > 0), 32'd1);
          if (acc_q.size() > 0) begin
            a = acc_q.pop_front();
            check("busy_addr", {8'h03, cap_w[0][23:0]}, {8'h03, a});
            check("busy_data", rd_w[0], {24'h0, mem[a[8:0]]});
          end
        end
      end
      if (c < 200) begin
        req_a[0] = 1'b1; size_a[0] = 2'd0;
        addr_a[0] = 24'hAB0000 | 24'((c * 37) & 511);
        if (rdy_w[0]) begin
          acc_q.push_back(addr_a[0]);
          n_acc++;
        end
      end else begin
        req_a[0] = 1'b0;
      end
    end
    check("busy_n_acc", n_acc, 32'd3);
    check("busy_n_rv", n_bv, 32'd3);

    // reset in the middle of a word read
    req_a[1] = 1'b1; addr_a[1] = 24'h000100; size_a[1] = 2'd2;
    n_rv = 0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (c == 1) req_a[1] = 1'b0;
      if (rv_w[1]) n_rv++;
      if (c == 20) rst = 1'b1;
      if (c == 21) begin
        check("mid_csb", 32'(csb_w[1]), 32'd1);
        check("mid_sck", 32'(sck_w[1]), 32'd0);
      end
      if (c == 22) rst = 1'b0;
    end
    check("mid_no_rv", n_rv, 32'd0);
    check("mid_rdata", rd_w[1], 32'd0);
    do_read(1, 24'h000010, 2'd0, rv_c, rdy_c, data, n_rv, csb1);
    check("mid_after_rdata", data, 32'h000000A5);
    check("mid_after_rv_cyc", rv_c, 32'd163);
    check("mid_after_rdy_cyc", rdy_c, 32'd167);

    // back-to-back, size 1 then size 3
    do_read(1, 24'h000000, 2'd1, rv_c, rdy_c, data, n_rv, csb1);
    check("bb1_rdata", data, 32'h0000C1C0);
    check("bb1_rv_cyc", rv_c, 32'd195);
    check("bb1_sck_edges", nbits_w[1], 32'd48);
    do_read(1, 24'h000004, 2'd3, rv_c, rdy_c, data, n_rv, csb1);
    check("bb2_mosi", cap_w[1], 32'h03000004);
    check("bb2_rdata", data, 32'hC7C6C5C4);
    check("bb2_rv_cyc", rv_c, 32'd259);
    check("bb2_sck_edges", nbits_w[1], 32'd64);
    check("bb_gap", last_gap, 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
